ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte (e.g. set-LEDs 0xED, reset 0xFF) from the host to the keyboard over the shared open-drain ps2_clk/ps2_data lines.
- Sits beside the existing PS/2 scan-code receiver. Drives the lines only through active-low-drive enables; the board pads are open-drain with pull-ups.
- Reports device ACK or timeout. While busy is high, the receiver must ignore the lines.

Parameters:
- INHIBIT_CYCLES, 5000, clk cycles ps2_clk is held low before the start bit (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000, max clk cycles between consecutive device falling edges, or from clock release to the first edge (15 ms at 50 MHz).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- tx_data  in  8  command byte; sampled on the accept cycle.
- tx_valid  in  1  request to send.
- tx_ready  out  1  high only in IDLE; accept = tx_valid & tx_ready.
- ps2_clk  in  1  raw clock line (asynchronous).
- ps2_data  in  1  raw data line (asynchronous).
- ps2_clk_drive_low  out  1  1 = pull the clock line low.
- ps2_data_drive_low  out  1  1 = pull the data line low.
- busy  out  1  high from the accept cycle until return to IDLE.
- done  out  1  one-cycle pulse at the end of every transaction.
- ack_ok  out  1  status: the device acknowledged. Held until the next accept.
- err_timeout  out  1  status: the transaction timed out. Held until the next accept.

Behaviour:
- Reset: state IDLE. tx_ready=1 from the first cycle after reset. All other outputs 0. Reset mid-transaction releases both lines on the next edge.
- ps2_clk and ps2_data each pass through a 3-flop synchronizer.
- fall = synced clock high at the previous stage and low at the current stage. Every bit action below is taken on the cycle fall is true.
- Accept: latch the byte, compute parity = ~^tx_data (odd parity), clear ack_ok and err_timeout, and go to INHIBIT.
- INHIBIT: clk_drive_low=1 for INHIBIT_CYCLES cycles. Then data_drive_low=1 and go to REQ.
- REQ: set clk_drive_low=0 and keep data_drive_low=1; this is the start bit. Wait for the first fall.
- On fall 1 through 8: data_drive_low = ~bit[i] for i=0..7, LSB first; the state is DATA with a 3-bit index.
- On fall 9: data_drive_low = ~parity (state PARITY).
- On fall 10: data_drive_low=0, the stop bit (state STOP).
- On fall 11: sample synced data. ack_ok = (data==0). Go to WAIT_IDLE.
- WAIT_IDLE: wait until synced clk and synced data are both 1. Then pulse done and go to IDLE.
- Timeout counter:
  - Cleared on entering REQ and on every fall.
  - Counts in REQ, DATA, PARITY, STOP and ACK, plus WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES releases both lines, sets err_timeout=1, pulses done and goes to IDLE.
  - err_timeout and ack_ok are never both 1.
- No ACK: a high line at fall 11 gives ack_ok=0 and err_timeout=0, still with a done pulse. The caller retries.
- A new tx_valid during busy is ignored; tx_ready=0.
- The done pulse and the return to IDLE happen in the same cycle. A tx_valid held high is accepted on the next cycle.
- Counter widths are sized with $clog2 of the larger parameter. Counters must not wrap.

Decomposition:
- Package ps2_pkg holds:
  - the state enum (IDLE, INHIBIT, REQ, DATA, PARITY, STOP, ACK, WAIT_IDLE);
  - command constants PS2_CMD_SET_LEDS=8'hED, PS2_CMD_ECHO=8'hEE, PS2_CMD_RESET=8'hFF;
  - device reply constants PS2_RSP_ACK=8'hFA, PS2_RSP_RESEND=8'hFE.
- One sub-module, ps2_line_sync: 3-flop synchronizer plus falling-edge detect. It is shared with the receiver.

Test Plan (bench overrides INHIBIT_CYCLES=20, TIMEOUT_CYCLES=200; device model clocks with a 40-cycle period and drives ACK low at fall 11):
- Send 0xED. Clk is held low for 20 cycles, then data goes low. Bits sampled on device rising edges are 1,0,1,1,0,1,1,1, parity 1, stop 1. Result: ack_ok=1, done pulses once, busy drops the same cycle.
- Send 0xF4. Data bits are 0,0,1,0,1,1,1,1 and parity is 0. Send 0x00: parity 1. Send 0xFF: parity 1. All end with ack_ok=1.
- Device never clocks after release. Timeout fires 200 cycles after REQ: err_timeout=1, ack_ok=0, both drive outputs 0, tx_ready=1 on the next cycle.
- Device stops after fall 5. Timeout fires 200 cycles after fall 5. Then a new send of 0xEE completes with ack_ok=1, proving the stale index was cleared.
- Device leaves data high at fall 11. Result: ack_ok=0, err_timeout=0, done pulses.
- Assert rst at fall 6. Both drive outputs are 0 and tx_ready=1 one cycle later. A tx_valid pulse during busy is not accepted, checked by the byte count in the device model.

Source files
------------

// File: rtl/ps2_pkg.sv
// PS/2 host-side shared types: transmitter state encoding, command and reply bytes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

    // Host-to-device transmit sequencer states
    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        DATA,
        PARITY,
        STOP,
        ACK,
        WAIT_IDLE
    } ps2_tx_state_e;

    // Host commands
    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    // Device replies
    localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;
    localparam logic [7:0] PS2_RSP_RESEND   = 8'hFE;

    // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronizes the raw PS/2 clock and data lines and flags falling edges of the clock.
// Latency: line change visible on *_level three cycles later; clk_fall one cycle earlier.
// Backpressure: none, free-running.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_level,
    output logic data_level,
    output logic clk_fall
);

    logic [2:0] clk_sync_q, clk_sync_d;
    logic [2:0] data_sync_q, data_sync_d;

    // Shift each raw line into its chain; bit 0 may go metastable, bit 2 is the settled level
    always_comb begin
        clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
        data_sync_d = {data_sync_q[1:0], ps2_data};
    end

    // Reset to the idle (pulled-up) level so leaving reset never looks like a falling edge
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= 3'b111;
            data_sync_q <= 3'b111;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
        end
    end

    // Data level is taken from the same stage as the clock level so both stay time-aligned
    assign clk_level  = clk_sync_q[2];
    assign data_level = data_sync_q[2];
    assign clk_fall   = clk_sync_q[2] & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 8 data + parity + stop, ACK check.
// Latency: INHIBIT_CYCLES plus 11 device clocks plus line-idle wait; done pulses on return to IDLE.
// Backpressure: tx_ready only in IDLE; tx_valid while busy is ignored.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       err_timeout
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic clk_level, data_level, clk_fall;

    ps2_line_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .clk_level  (clk_level),
        .data_level (data_level),
        .clk_fall   (clk_fall)
    );

    ps2_tx_state_e    state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic             parity_q, parity_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_dl_q, clk_dl_d;
    logic             data_dl_q, data_dl_d;
    logic             done_q, done_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             counting;
    logic [2:0]       nxt_idx;

    // Next-state logic: one bit action per device falling edge, watchdog on the device clock
    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        parity_d  = parity_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        clk_dl_d  = clk_dl_q;
        data_dl_d = data_dl_q;
        done_d    = 1'b0;
        ack_d     = ack_q;
        err_d     = err_q;
        nxt_idx   = idx_q + 3'd1;
        // The counter serves the inhibit timer in INHIBIT and the watchdog everywhere after it
        counting  = (state_q != IDLE) && (state_q != INHIBIT);

        if (counting) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    byte_d   = tx_data;
                    parity_d = odd_parity(tx_data);
                    ack_d    = 1'b0;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    clk_dl_d = 1'b1;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    // Data goes low while clock is still held, then clock is released in REQ
                    data_dl_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = REQ;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REQ: begin
                clk_dl_d = 1'b0;
                if (clk_fall) begin
                    data_dl_d = ~byte_q[0];
                    idx_d     = 3'd0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (clk_fall) begin
                    if (idx_q == 3'd7) begin
                        data_dl_d = ~parity_q;
                        state_d   = PARITY;
                    end else begin
                        data_dl_d = ~byte_q[nxt_idx];
                        idx_d     = nxt_idx;
                    end
                end
            end
            PARITY: begin
                if (clk_fall) begin
                    data_dl_d = 1'b0;
                    state_d   = STOP;
                end
            end
            STOP: begin
                // Device samples the stop bit on this rising edge; the ACK arrives on the next fall
                if (clk_level) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                if (clk_fall) begin
                    ack_d   = ~data_level;
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_level && data_level) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (counting && clk_fall) begin
            cnt_d = '0;
        end

        // Device went quiet: let go of both lines and report
        if (counting && !clk_fall && (cnt_q == TO_LAST)) begin
            state_d   = IDLE;
            clk_dl_d  = 1'b0;
            data_dl_d = 1'b0;
            ack_d     = 1'b0;
            err_d     = 1'b1;
            done_d    = 1'b1;
        end
    end

    // State and registered outputs; reset releases both lines on the next edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            byte_q    <= '0;
            parity_q  <= 1'b0;
            idx_q     <= '0;
            cnt_q     <= '0;
            clk_dl_q  <= 1'b0;
            data_dl_q <= 1'b0;
            done_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            parity_q  <= parity_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            clk_dl_q  <= clk_dl_d;
            data_dl_q <= data_dl_d;
            done_q    <= done_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    assign tx_ready           = (state_q == IDLE);
    assign busy               = (state_q != IDLE);
    assign done               = done_q;
    assign ack_ok             = ack_q;
    assign err_timeout        = err_q;
    assign ps2_clk_drive_low  = clk_dl_q;
    assign ps2_data_drive_low = data_dl_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed and random host-to-device transfers against a PS/2 device model with open-drain lines.
// Latency: n/a.
// Backpressure: n/a.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 20;
    localparam int TO  = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, done, ack_ok, err_timeout;
    logic       clk_dl, data_dl;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_w, ps2_data_w;

    // Open-drain wired-AND of host and device drivers
    assign ps2_clk_w  = dev_clk & ~clk_dl;
    assign ps2_data_w = dev_data & ~data_dl;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk                (clk),
        .rst                (rst),
        .tx_data            (tx_data),
        .tx_valid           (tx_valid),
        .tx_ready           (tx_ready),
        .ps2_clk            (ps2_clk_w),
        .ps2_data           (ps2_data_w),
        .ps2_clk_drive_low  (clk_dl),
        .ps2_data_drive_low (data_dl),
        .busy               (busy),
        .done               (done),
        .ack_ok             (ack_ok),
        .err_timeout        (err_timeout)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   done_cnt = 0;
    int   xact_cnt = 0;
    logic prev_cdl = 1'b0;
    int   total = 0;
    int   bad = 0;

    // Cycle counter, done pulse counter, and count of transactions the device sees start
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        prev_cdl <= clk_dl;
        if (done) done_cnt <= done_cnt + 1;
        if (clk_dl && !prev_cdl) xact_cnt <= xact_cnt + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference frame as the device should see it: LSB-first data, odd parity, stop=1
    function automatic logic [9:0] frame(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b};
    endfunction

    // Issue one request and act as the device for up to stop_after clock pulses
    task automatic run_xact(input logic [7:0] b, input int stop_after, input bit ack_low,
                            input int poke_at, input int rst_at,
                            output int inh_len, output int t_req, output int t_fall,
                            output logic [9:0] got_bits, output bit start_low);
        int n;
        inh_len   = 0;
        t_req     = 0;
        t_fall    = 0;
        got_bits  = '0;
        start_low = 1'b0;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        n = 0;
        while (clk_dl && !data_dl && n < 1000) begin
            inh_len++;
            n++;
            @(negedge clk);
        end
        t_req = cyc;
        n = 0;
        while (clk_dl && n < 100) begin
            n++;
            @(negedge clk);
        end
        start_low = (ps2_data_w == 1'b0);
        for (int f = 1; f <= stop_after; f++) begin
            repeat (10) @(negedge clk);
            if (f == 11) dev_data = ack_low ? 1'b0 : 1'b1;
            repeat (10) @(negedge clk);
            dev_clk = 1'b0;
            t_fall  = cyc;
            if (f == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                return;
            end
            for (int i = 0; i < 20; i++) begin
                tx_valid = (f == poke_at) && (i == 0);
                tx_data  = ~b;
                @(negedge clk);
            end
            tx_valid = 1'b0;
            dev_clk  = 1'b1;
            if (f <= 10) got_bits[f-1] = ps2_data_w;
            if (f == 11) dev_data = 1'b1;
        end
    endtask

    // Wait (bounded) for the done pulse and check the end-of-transaction status
    task automatic finish_xact(input string tag, input bit exp_ack, input bit exp_err,
                               output int t_done);
        int n;
        int d0;
        d0 = done_cnt;
        n  = 0;
        while (!done && n < 600) begin
            n++;
            @(negedge clk);
        end
        t_done = cyc;
        chk({tag, "_done_seen"}, int'(done), 1);
        chk({tag, "_busy_at_done"}, int'(busy), 0);
        chk({tag, "_ack"}, int'(ack_ok), int'(exp_ack));
        chk({tag, "_err"}, int'(err_timeout), int'(exp_err));
        chk({tag, "_drives"}, int'({clk_dl, data_dl}), 0);
        @(negedge clk);
        chk({tag, "_ready_next"}, int'(tx_ready), 1);
        chk({tag, "_done_once"}, done_cnt - d0, 1);
    endtask

    task automatic full_send(input string tag, input logic [7:0] b, input bit ack_low);
        int inh, t_req, t_fall, t_done;
        logic [9:0] bits;
        bit st;
        run_xact(b, 11, ack_low, 0, 0, inh, t_req, t_fall, bits, st);
        chk({tag, "_inhibit_len"}, inh, INH);
        chk({tag, "_start_bit"}, int'(st), 1);
        chk({tag, "_frame"}, int'(bits), int'(frame(b)));
        finish_xact(tag, ack_low, 1'b0, t_done);
    endtask

    initial begin
        int inh, t_req, t_fall, t_done, x0, d0;
        logic [9:0] bits;
        bit st;
        logic [7:0] rb;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", int'(tx_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_outs", int'({done, ack_ok, err_timeout, clk_dl, data_dl}), 0);

        // Normal sends with ACK
        full_send("set_leds", PS2_CMD_SET_LEDS, 1'b1);
        full_send("enable", 8'hF4, 1'b1);
        full_send("zero", 8'h00, 1'b1);
        full_send("ones", PS2_CMD_RESET, 1'b1);
        for (int k = 0; k < 4; k++) begin
            rb = 8'($urandom);
            full_send($sformatf("rand%0d", k), rb, 1'b1);
        end

        // Device never clocks: timeout measured from REQ entry
        run_xact(8'h55, 0, 1'b0, 0, 0, inh, t_req, t_fall, bits, st);
        finish_xact("to_req", 1'b0, 1'b1, t_done);
        chk("to_req_delay", t_done - t_req, TO);

        // Device stalls after the fifth pulse, then a clean send must still frame correctly
        run_xact(8'hA5, 5, 1'b0, 0, 0, inh, t_req, t_fall, bits, st);
        finish_xact("to_mid", 1'b0, 1'b1, t_done);
        chk("to_mid_delay_window", int'((t_done - t_fall) >= TO && (t_done - t_fall) <= TO + 6), 1);
        full_send("echo_after_to", PS2_CMD_ECHO, 1'b1);

        // Device leaves data high at the acknowledge slot
        full_send("no_ack", 8'h3C, 1'b0);

        // Reset during the frame, with an extra request attempted while busy
        x0 = xact_cnt;
        d0 = done_cnt;
        run_xact(8'hC3, 11, 1'b1, 3, 6, inh, t_req, t_fall, bits, st);
        chk("midrst_drives", int'({clk_dl, data_dl}), 0);
        chk("midrst_ready", int'(tx_ready), 1);
        chk("busy_poke_ignored", xact_cnt - x0, 1);
        chk("midrst_no_done", done_cnt - d0, 0);
        rst     = 1'b0;
        dev_clk = 1'b1;
        repeat (10) @(negedge clk);
        full_send("after_rst", PS2_CMD_SET_LEDS, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
